// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, ROM address drive and IF/ID pipeline register.
// Ports: Clk, Reset (async, active-low), IF_ID_enable (0 = stall),
//   IF_ID_flush, branch_taken/branch_target (redirect), imem_addr/imem_data
//   (combinational ROM), pc_out, ID_instruction, ID_pc_plus4, ID_valid.
// Optional macro IF_PERF_CNT_EN adds saturating fetch_count/stall_count.
module if_fetch_stage #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IF_ID_enable,
  input  logic              IF_ID_flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       pc_out,
  output logic [31:0]       ID_instruction,
  output logic [31:0]       ID_pc_plus4,
  output logic              ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] p4_q, p4_d;
  logic        valid_q, valid_d;
  logic        squash;

  assign pc_plus4  = pc_q + 32'd4;
  assign squash    = branch_taken | IF_ID_flush;
  assign imem_addr = pc_q[ADDR_W-1:0];

  // Redirect beats stall; target is forced to a word boundary.
  always_comb begin
    pc_d = pc_q;
    priority case (1'b1)
      branch_taken:  pc_d = branch_target & 32'hFFFF_FFFC;
      !IF_ID_enable: pc_d = pc_q;
      default:       pc_d = pc_plus4;
    endcase
  end

  // Squash beats stall so a redirect never leaves a stale word in ID.
  always_comb begin
    instr_d = instr_q;
    p4_d    = p4_q;
    valid_d = valid_q;
    priority case (1'b1)
      squash: begin
        instr_d = NOP_WORD;
        p4_d    = 32'd0;
        valid_d = 1'b0;
      end
      !IF_ID_enable: begin
        instr_d = instr_q;
        p4_d    = p4_q;
        valid_d = valid_q;
      end
      default: begin
        instr_d = imem_data;
        p4_d    = pc_plus4;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      p4_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      p4_q    <= p4_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out         = pc_q;
  assign ID_instruction = instr_q;
  assign ID_pc_plus4    = p4_q;
  assign ID_valid       = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic        fetch_inc, stall_inc;

  assign fetch_inc = IF_ID_enable & ~squash;
  assign stall_inc = ~IF_ID_enable & ~branch_taken;

  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (fetch_inc && fcnt_q != 16'hFFFF)
      fcnt_d = fcnt_q + 16'd1;
    if (stall_inc && scnt_q != 16'hFFFF)
      scnt_d = scnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fcnt_q <= 16'd0;
      scnt_q <= 16'd0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench for if_fetch_stage.
// Define IF_PERF_CNT_EN to also check the counters.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IF_ID_enable;
  logic        IF_ID_flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] ID_instruction;
  logic [31:0] ID_pc_plus4;
  logic        ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic [31:0] rom [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  assign imem_data = rom[imem_addr];

  if_fetch_stage #(
    .ADDR_W(8), .RESET_PC(32'h0), .NOP_WORD(NOP)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .IF_ID_enable(IF_ID_enable),
    .IF_ID_flush(IF_ID_flush),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .pc_out(pc_out),
    .ID_instruction(ID_instruction),
    .ID_pc_plus4(ID_pc_plus4),
    .ID_valid(ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  function automatic logic [31:0] w(input int idx);
    return 32'hE3A0_0000 | idx;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_id(input string tag,
                        input logic [31:0] pc,
                        input logic [31:0] ins,
                        input logic [31:0] p4,
                        input logic        v);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".ins"}, ID_instruction, ins);
    chk({tag, ".p4"}, ID_pc_plus4, p4);
    chk({tag, ".v"}, {31'd0, ID_valid}, {31'd0, v});
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      rom[a] = w(a >> 2);

    Reset = 1'b0;
    IF_ID_enable = 1'b1;
    IF_ID_flush = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;

    // Reset then straight-line run
    #2;
    chk_id("rst", 32'h0, NOP, 32'h0, 1'b0);
    chk("rst.addr", {24'd0, imem_addr}, 32'h0);
    #1 Reset = 1'b1;
    tick(); chk_id("run0", 32'd4,  w(0), 32'd4,  1'b1);
    tick(); chk_id("run1", 32'd8,  w(1), 32'd8,  1'b1);
    tick(); chk_id("run2", 32'd12, w(2), 32'd12, 1'b1);
    tick(); chk_id("run3", 32'd16, w(3), 32'd16, 1'b1);

    // Restart, advance to PC=8, then stall twice
    #2 Reset = 1'b0;
    #2 Reset = 1'b1;
    tick(); tick();
    chk_id("pre", 32'd8, w(1), 32'd8, 1'b1);
    IF_ID_enable = 1'b0;
    tick(); chk_id("stl0", 32'd8, w(1), 32'd8, 1'b1);
    tick(); chk_id("stl1", 32'd8, w(1), 32'd8, 1'b1);
    IF_ID_enable = 1'b1;
    tick(); chk_id("resume", 32'd12, w(2), 32'd12, 1'b1);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt2", {16'd0, stall_count}, 32'd2);
    chk("fetch_cnt3", {16'd0, fetch_count}, 32'd3);
`endif

    // Branch with unaligned target at PC=12
    branch_taken = 1'b1;
    branch_target = 32'h0000_0022;
    tick(); chk_id("br", 32'h20, NOP, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); chk_id("br+1", 32'h24, w(8), 32'h24, 1'b1);

    // Flush during stall: PC holds, ID squashed
    IF_ID_flush = 1'b1;
    IF_ID_enable = 1'b0;
    tick(); chk_id("flstl", 32'h24, NOP, 32'h0, 1'b0);
    // Flush while advancing: PC moves on, ID squashed
    IF_ID_enable = 1'b1;
    tick(); chk_id("fladv", 32'h28, NOP, 32'h0, 1'b0);
    IF_ID_flush = 1'b0;

    // Branch and stall together: redirect wins
    branch_taken = 1'b1;
    IF_ID_enable = 1'b0;
    branch_target = 32'h0000_0010;
    tick(); chk_id("brstl", 32'h10, NOP, 32'h0, 1'b0);
    branch_taken = 1'b0;
    IF_ID_enable = 1'b1;
    tick(); chk_id("adv14", 32'h14, w(4), 32'h14, 1'b1);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt3", {16'd0, stall_count}, 32'd3);
    chk("fetch_cnt5", {16'd0, fetch_count}, 32'd5);
`endif

    // Async reset between edges at PC=0x14
    #2 Reset = 1'b0;
    #1;
    chk_id("arst", 32'h0, NOP, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("arst.fc", {16'd0, fetch_count}, 32'd0);
    chk("arst.sc", {16'd0, stall_count}, 32'd0);
`endif
    #2 Reset = 1'b1;

    // Wrap and ROM aliasing
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    tick(); chk_id("hi", 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
    chk("hi.addr", {24'd0, imem_addr}, 32'h0000_00FC);
    branch_taken = 1'b0;
    tick(); chk_id("wrap", 32'h0, w(63), 32'h0, 1'b1);
    chk("wrap.addr", {24'd0, imem_addr}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
